param_sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO. Next generation of the team's 32-bit x 8 FIFO.

---
 rtl/param_sync_fifo.sv | 135 +++++++++++++
 tb/tb_param_sync_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo
//   Single-clock FIFO with configurable width and depth. It buffers words
//   between a producer (push) and a consumer (pop) in one clock domain. It
//   also provides an occupancy count, almost-full/almost-empty flags, a
//   synchronous flush, and sticky overflow/underflow error flags.
//
//   Parameters
//     DATA_WIDTH  word width in bits
//     ADDR_WIDTH  log2(depth); depth = 1 << ADDR_WIDTH
//     AF_THRESH   almost_full  when count >= AF_THRESH
//     AE_THRESH   almost_empty when count <= AE_THRESH
//     FWFT        0 = registered read (1-cycle latency),
//                 1 = first-word-fall-through
//
//   Ports
//     clk           clock, rising edge
//     rst           asynchronous reset, active low
//     flush         synchronous clear of contents and error flags
//     push/data_in  write request and write data
//     pop           read request
//     data_out      read data
//     ready         data_out valid
//     empty, full, almost_full, almost_empty   occupancy flags
//     count         occupancy, 0..DEPTH
//     overflow      sticky: push rejected while full
//     underflow     sticky: pop rejected while empty
module param_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the address bits match.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  push_ok;
  logic                  pop_ok;

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // Occupancy is the modulo-2*DEPTH pointer difference. This equals the
  // running sum of count + push_ok - pop_ok.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_addr == rd_addr) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign almost_full  = (int'(count) >= AF_THRESH);
  assign almost_empty = (int'(count) <= AE_THRESH);

  // A push into a full FIFO is allowed when a pop frees a slot on the same
  // edge. The write then lands in the slot being read out.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // ---- stage p0: storage write, pointers, error flags ----
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // The head word is always visible at the output. A pop simply advances
      // rd_ptr, so the next word shows on the same edge.
      assign data_out = mem[rd_addr];
      assign ready    = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // ---- stage p1: registered read ----
      // A rejected pop or a flush leaves the last word on data_out.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else if (flush) begin
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= pop_ok;
          if (pop_ok) rd_data_p1 <= mem[rd_addr];
        end
      end

      assign data_out = rd_data_p1;
      assign ready    = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo
//   Directed bench for param_sync_fifo. One instance uses the default
//   registered-read configuration. A second instance has FWFT=1.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read instance
  logic        rst = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        ready, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  // FWFT instance
  logic        f_rst = 1'b0, f_flush = 1'b0, f_push = 1'b0, f_pop = 1'b0;
  logic [31:0] f_data_in = '0;
  logic [31:0] f_data_out;
  logic        f_ready, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]  f_count;

  int n_cmp  = 0;
  int n_fail = 0;

  param_sync_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in),
    .pop(pop), .data_out(data_out), .ready(ready), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(f_rst), .flush(f_flush), .push(f_push), .data_in(f_data_in),
    .pop(f_pop), .data_out(f_data_out), .ready(f_ready), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_cmp++; if (empty !== 1'b1)        begin n_fail++; $display("FAIL rst_empty got %0b want 1", empty); end
    n_cmp++; if (full !== 1'b0)         begin n_fail++; $display("FAIL rst_full got %0b want 0", full); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae got %0b want 1", almost_empty); end
    n_cmp++; if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL rst_af got %0b want 0", almost_full); end
    n_cmp++; if (count !== 4'd0)        begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (ready !== 1'b0)        begin n_fail++; $display("FAIL rst_ready got %0b want 0", ready); end
    n_cmp++; if (data_out !== 32'h0)    begin n_fail++; $display("FAIL rst_data got %0h want 0", data_out); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_err got %0b want 00", {overflow, underflow}); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_order();
    logic [31:0] vals [7] = '{32'h0, 32'h1, 32'h3, 32'h3FF, 32'hF, 32'h1F, 32'h3F};
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; data_in = vals[i];
      tick();
      n_cmp++; if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL basic_count got %0d want %0d", count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 6)) begin n_fail++; $display("FAIL basic_af at %0d got %0b want %0b", i + 1, almost_full, (i + 1 >= 6)); end
    end
    push = 1'b0;
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL basic_full7 got %0b want 0", full); end
    for (int i = 0; i < 7; i++) begin
      pop = 1'b1;
      tick();
      n_cmp++; if (ready !== 1'b1)     begin n_fail++; $display("FAIL basic_ready%0d got %0b want 1", i, ready); end
      n_cmp++; if (data_out !== vals[i]) begin n_fail++; $display("FAIL basic_data%0d got %0h want %0h", i, data_out, vals[i]); end
      n_cmp++; if (almost_empty !== (6 - i <= 1)) begin n_fail++; $display("FAIL basic_ae%0d got %0b want %0b", i, almost_empty, (6 - i <= 1)); end
    end
    pop = 1'b0;
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop got %0b want 0", ready); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %0b want 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; data_in = 32'(i);
      tick();
      if (i == 7) begin
        n_cmp++; if (full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full got %0b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b want 0", overflow); end
      end
    end
    push = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    n_cmp++; if (count !== 4'd8)    begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      tick();
      n_cmp++; if (data_out !== 32'(i)) begin n_fail++; $display("FAIL ovf_data%0d got %0h want %0h", i, data_out, i); end
    end
    pop = 1'b0;
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flush got %0b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; data_in = 32'h10 + 32'(i);
      tick();
    end
    push = 1'b1; pop = 1'b1; data_in = 32'hAA;
    tick();
    push = 1'b0;
    n_cmp++; if (data_out !== 32'h10) begin n_fail++; $display("FAIL fpp_oldest got %0h want 10", data_out); end
    n_cmp++; if (count !== 4'd8)      begin n_fail++; $display("FAIL fpp_count got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) begin
        n_cmp++; if (data_out !== 32'h11 + 32'(i)) begin n_fail++; $display("FAIL fpp_data%0d got %0h want %0h", i, data_out, 32'h11 + i); end
      end else begin
        n_cmp++; if (data_out !== 32'hAA) begin n_fail++; $display("FAIL fpp_last got %0h want aa", data_out); end
      end
    end
    pop = 1'b0;
    tick();
  endtask

  task automatic test_underflow_flush();
    pop = 1'b1;
    tick();
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %0b want 1", underflow); end
    n_cmp++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL unf_ready got %0b want 0", ready); end
    n_cmp++; if (data_out !== 32'hAA) begin n_fail++; $display("FAIL unf_hold got %0h want aa", data_out); end
    push = 1'b1; data_in = 32'h77;
    tick();
    push = 1'b0; pop = 1'b0;
    n_cmp++; if (count !== 4'd1)     begin n_fail++; $display("FAIL unf_pp_count got %0d want 1", count); end
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got %0b want 1", underflow); end
    n_cmp++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL unf_pp_ready got %0b want 0", ready); end
    // flush wins over a simultaneous push
    flush = 1'b1; push = 1'b1; data_in = 32'h99;
    tick();
    flush = 1'b0; push = 1'b0;
    n_cmp++; if (underflow !== 1'b0)  begin n_fail++; $display("FAIL flush_unf got %0b want 0", underflow); end
    n_cmp++; if (count !== 4'd0)      begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL flush_empty got %0b want 1", empty); end
    n_cmp++; if (data_out !== 32'hAA) begin n_fail++; $display("FAIL flush_hold got %0h want aa", data_out); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      push = 1'b1; data_in = 32'h100 + 32'(i);
      tick();
      push = 1'b0; pop = 1'b1;
      n_cmp++; if (count > 4'd1) begin n_fail++; $display("FAIL wrap_count%0d got %0d want <=1", i, count); end
      tick();
      pop = 1'b0;
      n_cmp++; if (data_out !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL wrap_data%0d got %0h want %0h", i, data_out, 32'h100 + i); end
      n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_empty%0d got %0d want 0", i, count); end
    end
  endtask

  task automatic test_fwft();
    f_rst = 1'b1;
    tick();
    f_push = 1'b1; f_data_in = 32'h55;
    tick();
    f_push = 1'b0;
    n_cmp++; if (f_data_out !== 32'h55) begin n_fail++; $display("FAIL fwft_data got %0h want 55", f_data_out); end
    n_cmp++; if (f_ready !== 1'b1)      begin n_fail++; $display("FAIL fwft_ready got %0b want 1", f_ready); end
    f_push = 1'b1; f_data_in = 32'h66;
    tick();
    f_push = 1'b0;
    n_cmp++; if (f_data_out !== 32'h55) begin n_fail++; $display("FAIL fwft_head got %0h want 55", f_data_out); end
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    n_cmp++; if (f_data_out !== 32'h66) begin n_fail++; $display("FAIL fwft_adv got %0h want 66", f_data_out); end
    n_cmp++; if (f_count !== 4'd1)      begin n_fail++; $display("FAIL fwft_count got %0d want 1", f_count); end
    f_push = 1'b1; f_data_in = 32'h77;
    tick();
    f_push = 1'b0;
    // reset between edges: state must clear without a clock edge
    #2 f_rst = 1'b0;
    #1;
    n_cmp++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_rst_empty got %0b want 1", f_empty); end
    n_cmp++; if (f_count !== 4'd0) begin n_fail++; $display("FAIL fwft_rst_count got %0d want 0", f_count); end
    n_cmp++; if (f_ready !== 1'b0) begin n_fail++; $display("FAIL fwft_rst_ready got %0b want 0", f_ready); end
    f_rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_overflow();
    test_full_push_pop();
    test_underflow_flush();
    test_wrap();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
